// File: rtl/sample_page_writer.sv
// Collects sample packets into fixed-size pages, queues closed pages in a small
// FIFO and hands each one to the memory interface over a req/ack handshake.
module sample_page_writer #(
  parameter int     SAMPLE_PACKET_WIDTH = 32,
  parameter int     PACKETS_PER_PAGE    = 4,
  parameter int     FIFO_DEPTH          = 4,
  parameter longint MEMORY_CAPACITY     = 64'd1 << 27,
  parameter int     ADDR_WIDTH          = $clog2(MEMORY_CAPACITY)
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic                                          abort,
  input  logic                                          write_enable,
  input  logic [SAMPLE_PACKET_WIDTH-1:0]                samplePacket,
  input  logic [31:0]                                   sample_number,
  output logic                                          pageFull,
  output logic                                          mem_wr_req,
  output logic [ADDR_WIDTH-1:0]                         mem_wr_addr,
  output logic [SAMPLE_PACKET_WIDTH*PACKETS_PER_PAGE-1:0] mem_wr_data,
  input  logic                                          mem_wr_ack,
  output logic                                          overflow,
  output logic                                          drained
);

  localparam int SPW         = SAMPLE_PACKET_WIDTH;
  localparam int PPP         = PACKETS_PER_PAGE;
  localparam int PAGE_WIDTH  = SPW * PPP;
  localparam int SLOT_BITS   = $clog2(PPP);
  localparam int PTR_BITS    = $clog2(FIFO_DEPTH);
  localparam int PKT_BYTES   = SPW / 8;

  typedef enum logic {IDLE, REQ} state_t;

  state_t state, state_next;

  logic [SLOT_BITS-1:0]  slot;
  logic                  capture;
  logic                  close_page;
  logic [SPW-1:0]        page_buf [PPP];
  logic [PAGE_WIDTH-1:0] closing_page;
  logic [31:0]           page_sn;
  logic [63:0]           page_bytes;
  logic [ADDR_WIDTH-1:0] closing_addr;
  logic                  unused_addr_bits;

  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [PAGE_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr, rd_ptr;
  logic [PTR_BITS:0]     count, count_next;
  logic                  fifo_full;
  logic                  pop, push_ok, drop;

  // start and abort both discard any packet arriving on the same cycle
  assign slot       = sample_number[SLOT_BITS-1:0];
  assign capture    = write_enable & ~abort & ~start;
  assign close_page = capture & (&slot);

  always_comb begin
    for (int i = 0; i < PPP; i++) closing_page[i*SPW +: SPW] = page_buf[i];
    closing_page[PAGE_WIDTH-1 -: SPW] = samplePacket;
  end

  // Page base byte address; truncation to ADDR_WIDTH gives the modulo wrap
  assign page_sn          = {sample_number[31:SLOT_BITS], {SLOT_BITS{1'b0}}};
  assign page_bytes       = 64'(page_sn) * 64'(PKT_BYTES);
  assign closing_addr     = page_bytes[ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^page_bytes[63:ADDR_WIDTH];

  assign fifo_full = (count == (PTR_BITS+1)'(FIFO_DEPTH));
  assign pop       = (state == REQ) & mem_wr_ack;
  assign push_ok   = close_page & (~fifo_full | pop);
  assign drop      = close_page & fifo_full & ~pop;

  always_comb begin
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pageFull <= 1'b1;
      overflow <= 1'b0;
      for (int i = 0; i < PPP; i++) page_buf[i] <= '0;
    end else begin
      if (start || abort) begin
        pageFull <= 1'b1;
        for (int i = 0; i < PPP; i++) page_buf[i] <= '0;
      end else if (write_enable) begin
        page_buf[slot] <= samplePacket;
        pageFull       <= &slot;
      end
      if (start)     overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_addr[wr_ptr] <= closing_addr;
      fifo_data[wr_ptr] <= closing_page;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A page pushed alongside the last pop keeps the request up back-to-back
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != '0) state_next = REQ;
      REQ:     if (pop && count_next == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_wr_req  = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    if (state == REQ) begin
      mem_wr_req  = 1'b1;
      mem_wr_addr = fifo_addr[rd_ptr];
      mem_wr_data = fifo_data[rd_ptr];
    end
  end

  assign drained = (count == '0) & (state == IDLE);

endmodule

// File: tb/tb_sample_page_writer.sv
// Directed bench for sample_page_writer: closed pages go into a scoreboard and
// are compared against each accepted memory write.
module tb_sample_page_writer;

  localparam int     SPW = 32;
  localparam int     PPP = 4;
  localparam int     AW  = 27;
  localparam longint CAP = 64'd1 << 27;

  typedef struct {
    logic [AW-1:0]      addr;
    logic [SPW*PPP-1:0] data;
  } exp_t;

  logic               clk, reset, start, abort, write_enable, mem_wr_ack;
  logic [SPW-1:0]     samplePacket;
  logic [31:0]        sample_number;
  logic               pageFull, mem_wr_req, overflow, drained;
  logic [AW-1:0]      mem_wr_addr;
  logic [SPW*PPP-1:0] mem_wr_data;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   n_acked = 0;
  exp_t sb[$];
  logic [31:0] mslot [PPP];

  sample_page_writer #(
    .SAMPLE_PACKET_WIDTH(SPW),
    .PACKETS_PER_PAGE(PPP),
    .FIFO_DEPTH(4),
    .MEMORY_CAPACITY(CAP),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .write_enable(write_enable),
    .samplePacket(samplePacket),
    .sample_number(sample_number),
    .pageFull(pageFull),
    .mem_wr_req(mem_wr_req),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .mem_wr_ack(mem_wr_ack),
    .overflow(overflow),
    .drained(drained)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearModel();
    for (int i = 0; i < PPP; i++) mslot[i] = '0;
  endtask

  // One packet; a closing packet pushes the expected page unless it will be dropped
  task automatic applyStimulus(input logic [31:0] sn, input bit dropped);
    logic [31:0] pkt;
    exp_t        e;
    pkt           = $urandom;
    write_enable  = 1'b1;
    sample_number = sn;
    samplePacket  = pkt;
    tick();
    write_enable = 1'b0;
    if (sn[1:0] == 2'd3) begin
      if (!dropped) begin
        e.addr = AW'((64'({sn[31:2], 2'b00}) * 64'd4) % CAP);
        e.data = {pkt, mslot[2], mslot[1], mslot[0]};
        sb.push_back(e);
      end
      checkOutput("pageFull closed", pageFull, 1);
    end else begin
      mslot[sn[1:0]] = pkt;
      checkOutput("pageFull open", pageFull, 0);
    end
  endtask

  task automatic waitReq();
    int n = 0;
    while (!mem_wr_req && n < 50) begin
      tick();
      n++;
    end
    checkOutput("req timeout", mem_wr_req, 1);
  endtask

  task automatic ackOne(input int delay);
    waitReq();
    repeat (delay) tick();
    mem_wr_ack = 1'b1;
    tick();
    mem_wr_ack = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && mem_wr_req && mem_wr_ack) begin
      n_acked++;
      checkOutput("write expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("write addr", mem_wr_addr, e.addr);
        checkOutput("write data", mem_wr_data, e.data);
      end
    end
  end

  initial begin
    int base;
    reset = 1'b1; start = 1'b0; abort = 1'b0; write_enable = 1'b0;
    mem_wr_ack = 1'b0; samplePacket = '0; sample_number = '0;
    clearModel();
    tick();
    tick();
    checkOutput("reset pageFull", pageFull, 1);
    checkOutput("reset req", mem_wr_req, 0);
    checkOutput("reset addr", mem_wr_addr, 0);
    checkOutput("reset data", mem_wr_data, 0);
    checkOutput("reset overflow", overflow, 0);
    checkOutput("reset drained", drained, 1);
    reset = 1'b0;
    tick();

    // Two pages, request must appear one edge after the closing packet
    for (int i = 0; i < 4; i++) applyStimulus(i, 0);
    checkOutput("latency req low", mem_wr_req, 0);
    checkOutput("latency drained", drained, 0);
    applyStimulus(4, 0);
    checkOutput("latency req high", mem_wr_req, 1);
    checkOutput("page0 addr", mem_wr_addr, 27'h0);
    for (int i = 5; i < 8; i++) applyStimulus(i, 0);
    ackOne(2);
    checkOutput("page1 addr", mem_wr_addr, 27'h10);
    ackOne(2);
    checkOutput("drained after two", drained, 1);
    checkOutput("req low after two", mem_wr_req, 0);

    // Three queued pages drained with ack held high
    for (int i = 16; i < 28; i++) applyStimulus(i, 0);
    mem_wr_ack = 1'b1;
    base = n_acked;
    for (int i = 0; i < 3; i++) begin
      checkOutput("b2b req", mem_wr_req, 1);
      tick();
    end
    checkOutput("b2b req drop", mem_wr_req, 0);
    checkOutput("b2b pops", n_acked - base, 3);
    mem_wr_ack = 1'b0;
    tick();

    // Five pages with no ack: fifth is dropped and flags overflow
    for (int i = 32; i < 48; i++) applyStimulus(i, 0);
    checkOutput("overflow before", overflow, 0);
    for (int i = 48; i < 52; i++) applyStimulus(i, i == 51);
    checkOutput("overflow set", overflow, 1);
    checkOutput("head stable", mem_wr_addr, 27'h80);
    start = 1'b1;
    tick();
    start = 1'b0;
    clearModel();
    checkOutput("start clears overflow", overflow, 0);
    checkOutput("start pageFull", pageFull, 1);
    checkOutput("start keeps req", mem_wr_req, 1);
    for (int i = 0; i < 4; i++) ackOne(1);
    checkOutput("drained after overflow", drained, 1);

    // Sample number wrap
    for (int i = 0; i < 4; i++) applyStimulus(32'hFFFF_FFFC + i, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i, 0);
      if (i == 0) checkOutput("wrap addr", mem_wr_addr, 27'h7FF_FFF0);
    end
    ackOne(0);
    ackOne(0);

    // Partial page then abort; abort beats a simultaneous write
    applyStimulus(8, 0);
    applyStimulus(9, 0);
    abort = 1'b1; write_enable = 1'b1; sample_number = 10; samplePacket = $urandom;
    tick();
    abort = 1'b0; write_enable = 1'b0;
    clearModel();
    checkOutput("abort pageFull", pageFull, 1);
    tick();
    tick();
    checkOutput("abort no req", mem_wr_req, 0);
    checkOutput("abort drained", drained, 1);
    for (int i = 12; i < 16; i++) applyStimulus(i, 0);
    ackOne(1);

    // Reset in the middle of an outstanding request
    for (int i = 100; i < 104; i++) applyStimulus(i, 0);
    waitReq();
    applyStimulus(104, 0);
    reset = 1'b1;
    tick();
    checkOutput("midreset req", mem_wr_req, 0);
    checkOutput("midreset drained", drained, 1);
    checkOutput("midreset pageFull", pageFull, 1);
    checkOutput("midreset addr", mem_wr_addr, 0);
    reset = 1'b0;
    sb.delete();
    clearModel();
    tick();
    tick();
    checkOutput("post reset req", mem_wr_req, 0);

    checkOutput("scoreboard empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
